ft64_btb_update_ctrl: RTL and testbench

- Sequences all writes into the FT64 branch target buffer (1024 entries, indexed by pc[11:2]).
- Accepts branch-resolution updates from the two commit ports and buffers them in a small FIFO.
- Serialises the buffered updates onto the single BTB write port.
- Runs an invalidate sweep over all entries after reset and on a flush request; the sweep has priority over queued updates.

---
 rtl/ft64_btb_update_ctrl.sv | 152 +++++++++++++++
 tb/tb_ft64_btb_update_ctrl.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/ft64_btb_update_ctrl.sv
`default_nettype none
// ============================================================================
// ft64_btb_update_ctrl
// Serialises commit-port branch updates and invalidate sweeps onto the BTB
// write port.
// Revision: 1.0
// ============================================================================
module ft64_btb_update_ctrl #(
  parameter int              AMSB    = 31,
  parameter logic [AMSB:0]   RSTPC   = 32'hFFFC0100,
  parameter int              QDEPTH  = 4,
  parameter int              ENTRIES = 1024
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            upd_v0,
  input  logic [AMSB:0]   upd_pc0,
  input  logic [AMSB:0]   upd_tgt0,
  input  logic            upd_tkn0,
  input  logic            upd_v1,
  input  logic [AMSB:0]   upd_pc1,
  input  logic [AMSB:0]   upd_tgt1,
  input  logic            upd_tkn1,
  output logic            upd_rdy0,
  output logic            upd_rdy1,
  input  logic            flush_req,
  output logic            btb_wr,
  output logic [AMSB:0]   btb_wadr,
  output logic [AMSB:0]   btb_wdat,
  output logic            btb_valid,
  output logic            busy
);

  localparam int AW = AMSB + 1;
  localparam int PW = $clog2(QDEPTH);
  localparam int CW = PW + 1;
  localparam int IW = $clog2(ENTRIES);
  localparam int EW = 2 * AW + 1;

  typedef enum logic [0:0] {
    SWEEP = 1'b0,
    IDLE  = 1'b1
  } state_t;

  state_t          state, state_nx;
  logic [IW-1:0]   idx, idx_nx;
  logic [EW-1:0]   mem [QDEPTH];
  logic [PW-1:0]   rd_ptr, rd_ptr_nx;
  logic [PW-1:0]   wr_ptr, wr_ptr_nx;
  logic [CW-1:0]   count, count_nx;
  logic            wr_nx, valid_nx, busy_nx, rdy0_nx, rdy1_nx;
  logic [AW-1:0]   wadr_nx, wdat_nx;
  logic            push0, push1, pop;
  logic [EW-1:0]   head;
  logic [EW-1:0]   ent0, ent1;

  // Ready is low during a sweep, so accepted pushes only ever land in IDLE.
  assign push0 = upd_v0 && upd_rdy0 && !flush_req;
  assign push1 = upd_v1 && upd_rdy1 && !flush_req;
  assign pop   = (state == IDLE) && (count != '0) && !flush_req;
  assign head  = mem[rd_ptr];
  assign ent0  = {upd_pc0, upd_tgt0, upd_tkn0};
  assign ent1  = {upd_pc1, upd_tgt1, upd_tkn1};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= SWEEP;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    idx_nx    = idx;
    wr_nx     = 1'b0;
    wadr_nx   = btb_wadr;
    wdat_nx   = btb_wdat;
    valid_nx  = btb_valid;
    busy_nx   = busy;
    rd_ptr_nx = rd_ptr + PW'(pop);
    wr_ptr_nx = wr_ptr + PW'(push0) + PW'(push1);
    count_nx  = count + CW'(push0) + CW'(push1) - CW'(pop);

    if (flush_req) begin
      state_nx  = SWEEP;
      idx_nx    = '0;
      busy_nx   = 1'b1;
      rd_ptr_nx = '0;
      wr_ptr_nx = '0;
      count_nx  = '0;
    end else begin
      case (state)
        SWEEP: begin
          wr_nx    = 1'b1;
          wadr_nx  = AW'({idx, 2'b00});
          wdat_nx  = RSTPC;
          valid_nx = 1'b0;
          idx_nx   = idx + 1'b1;
          if (idx == IW'(ENTRIES - 1)) begin
            state_nx = IDLE;
            busy_nx  = 1'b0;
            idx_nx   = '0;
          end
        end
        IDLE: begin
          if (pop) begin
            wr_nx                        = 1'b1;
            {wadr_nx, wdat_nx, valid_nx} = head;
          end
        end
        default: state_nx = SWEEP;
      endcase
    end

    rdy0_nx = !busy_nx && (count_nx <= CW'(QDEPTH - 1));
    rdy1_nx = !busy_nx && (count_nx <= CW'(QDEPTH - 2));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx       <= '0;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      btb_wr    <= 1'b0;
      btb_wadr  <= '0;
      btb_wdat  <= '0;
      btb_valid <= 1'b0;
      busy      <= 1'b1;
      upd_rdy0  <= 1'b0;
      upd_rdy1  <= 1'b0;
    end else begin
      idx       <= idx_nx;
      rd_ptr    <= rd_ptr_nx;
      wr_ptr    <= wr_ptr_nx;
      count     <= count_nx;
      btb_wr    <= wr_nx;
      btb_wadr  <= wadr_nx;
      btb_wdat  <= wdat_nx;
      btb_valid <= valid_nx;
      busy      <= busy_nx;
      upd_rdy0  <= rdy0_nx;
      upd_rdy1  <= rdy1_nx;
    end
  end

  // Port 0 takes the first free slot so the younger port-1 update drains later.
  always_ff @(posedge clk) begin
    if (push0) mem[wr_ptr] <= ent0;
    if (push1) mem[push0 ? PW'(wr_ptr + 1'b1) : wr_ptr] <= ent1;
  end

endmodule
`default_nettype wire

// File: tb/tb_ft64_btb_update_ctrl.sv
`default_nettype none
// tb_ft64_btb_update_ctrl: vector table, hand-written sweep/reset sequences and
// randomized traffic checked against a queue-based reference model.
module tb_ft64_btb_update_ctrl;

  localparam logic [31:0] RSTPC   = 32'hFFFC0100;
  localparam int          ENTRIES = 1024;
  localparam int          QDEPTH  = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        upd_v0, upd_tkn0, upd_v1, upd_tkn1, flush_req;
  logic [31:0] upd_pc0, upd_tgt0, upd_pc1, upd_tgt1;
  logic        upd_rdy0, upd_rdy1, btb_wr, btb_valid, busy;
  logic [31:0] btb_wadr, btb_wdat;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  ft64_btb_update_ctrl #(
    .AMSB(31), .RSTPC(RSTPC), .QDEPTH(QDEPTH), .ENTRIES(ENTRIES)
  ) dut (
    .clk(clk), .rst(rst),
    .upd_v0(upd_v0), .upd_pc0(upd_pc0), .upd_tgt0(upd_tgt0), .upd_tkn0(upd_tkn0),
    .upd_v1(upd_v1), .upd_pc1(upd_pc1), .upd_tgt1(upd_tgt1), .upd_tkn1(upd_tkn1),
    .upd_rdy0(upd_rdy0), .upd_rdy1(upd_rdy1), .flush_req(flush_req),
    .btb_wr(btb_wr), .btb_wadr(btb_wadr), .btb_wdat(btb_wdat),
    .btb_valid(btb_valid), .busy(busy)
  );

  // Observed bundle: {wr, wadr, wdat, valid, busy, rdy0, rdy1}
  function automatic logic [68:0] pk(logic wr, logic [31:0] adr, logic [31:0] dat,
                                     logic val, logic bsy, logic r0, logic r1);
    return {wr, adr, dat, val, bsy, r0, r1};
  endfunction

  function automatic logic [68:0] got();
    return {btb_wr, btb_wadr, btb_wdat, btb_valid, busy, upd_rdy0, upd_rdy1};
  endfunction

  task automatic chk(input string name, input logic [68:0] exp);
    logic [68:0] g;
    g = got();
    vectors++;
    if (g !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, g, exp);
    end
  endtask

  // Reference model: a plain queue of pending updates plus a sweep counter.
  typedef struct {
    logic [31:0] pc;
    logic [31:0] tgt;
    logic        tkn;
  } ent_t;

  ent_t        q[$];
  bit          m_sweep;
  int          m_idx;
  logic        m_wr, m_val, m_busy, m_rdy0, m_rdy1;
  logic [31:0] m_adr, m_dat;

  function automatic void model_reset();
    q.delete();
    m_sweep = 1'b1; m_idx = 0;
    m_wr = 1'b0; m_adr = '0; m_dat = '0; m_val = 1'b0;
    m_busy = 1'b1; m_rdy0 = 1'b0; m_rdy1 = 1'b0;
  endfunction

  function automatic void model_edge();
    bit   a0, a1;
    ent_t e;
    a0 = upd_v0 && m_rdy0 && !flush_req;
    a1 = upd_v1 && m_rdy1 && !flush_req;
    if (flush_req) begin
      q.delete();
      m_sweep = 1'b1; m_idx = 0; m_wr = 1'b0; m_busy = 1'b1;
    end else if (m_sweep) begin
      m_wr = 1'b1; m_adr = 32'(m_idx * 4); m_dat = RSTPC; m_val = 1'b0;
      m_idx++;
      if (m_idx == ENTRIES) begin
        m_sweep = 1'b0; m_busy = 1'b0;
      end
    end else begin
      if (q.size() > 0) begin
        e = q.pop_front();
        m_wr = 1'b1; m_adr = e.pc; m_dat = e.tgt; m_val = e.tkn;
      end else begin
        m_wr = 1'b0;
      end
      if (a0) q.push_back('{upd_pc0, upd_tgt0, upd_tkn0});
      if (a1) q.push_back('{upd_pc1, upd_tgt1, upd_tkn1});
    end
    m_rdy0 = !m_busy && (q.size() <= QDEPTH - 1);
    m_rdy1 = !m_busy && (q.size() <= QDEPTH - 2);
  endfunction

  task automatic step();
    @(posedge clk);
    if (rst) model_edge();
    #1;
  endtask

  task automatic clear_in();
    upd_v0 = 0; upd_pc0 = '0; upd_tgt0 = '0; upd_tkn0 = 0;
    upd_v1 = 0; upd_pc1 = '0; upd_tgt1 = '0; upd_tkn1 = 0;
    flush_req = 0;
  endtask

  task automatic sweep_check(input string name);
    for (int i = 0; i < ENTRIES; i++) begin
      step();
      chk(name, pk(1'b1, 32'(i * 4), RSTPC, 1'b0, i != ENTRIES - 1,
                   i == ENTRIES - 1, i == ENTRIES - 1));
    end
    step();
    chk({name, "_end"}, pk(1'b0, 32'hFFC, RSTPC, 1'b0, 1'b0, 1'b1, 1'b1));
  endtask

  typedef struct {
    logic        v0;
    logic [31:0] pc0, tgt0;
    logic        tkn0;
    logic        v1;
    logic [31:0] pc1, tgt1;
    logic        tkn1;
    logic        flush;
    logic [68:0] exp;
  } vec_t;

  function automatic vec_t mk(logic v0, logic [31:0] pc0, logic [31:0] tgt0, logic tkn0,
                              logic v1, logic [31:0] pc1, logic [31:0] tgt1, logic tkn1,
                              logic fl, logic [68:0] exp);
    vec_t v;
    v.v0 = v0; v.pc0 = pc0; v.tgt0 = tgt0; v.tkn0 = tkn0;
    v.v1 = v1; v.pc1 = pc1; v.tgt1 = tgt1; v.tkn1 = tkn1;
    v.flush = fl; v.exp = exp;
    return v;
  endfunction

  vec_t tbl[16];

  initial begin
    tbl[0]  = mk(1, 32'h1000, 32'h2000, 1, 0, 0, 0, 0, 0, pk(0, 32'hFFC, RSTPC, 0, 0, 1, 1));
    tbl[1]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, pk(1, 32'h1000, 32'h2000, 1, 0, 1, 1));
    tbl[2]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, pk(0, 32'h1000, 32'h2000, 1, 0, 1, 1));
    tbl[3]  = mk(1, 32'h1040, 32'h3000, 1, 1, 32'h1040, 32'h4000, 0, 0,
                 pk(0, 32'h1000, 32'h2000, 1, 0, 1, 1));
    tbl[4]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, pk(1, 32'h1040, 32'h3000, 1, 0, 1, 1));
    tbl[5]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, pk(1, 32'h1040, 32'h4000, 0, 0, 1, 1));
    tbl[6]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, pk(0, 32'h1040, 32'h4000, 0, 0, 1, 1));
    tbl[7]  = mk(1, 32'h2000, 32'h2100, 1, 1, 32'h2004, 32'h2104, 0, 0,
                 pk(0, 32'h1040, 32'h4000, 0, 0, 1, 1));
    tbl[8]  = mk(1, 32'h2008, 32'h2108, 1, 1, 32'h200C, 32'h210C, 1, 0,
                 pk(1, 32'h2000, 32'h2100, 1, 0, 1, 0));
    tbl[9]  = mk(0, 0, 0, 0, 1, 32'h2FF0, 32'h2FF4, 1, 0,
                 pk(1, 32'h2004, 32'h2104, 0, 0, 1, 1));
    tbl[10] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, pk(1, 32'h2008, 32'h2108, 1, 0, 1, 1));
    tbl[11] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, pk(1, 32'h200C, 32'h210C, 1, 0, 1, 1));
    tbl[12] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, pk(0, 32'h200C, 32'h210C, 1, 0, 1, 1));
    tbl[13] = mk(1, 32'h3000, 32'h3100, 1, 1, 32'h3004, 32'h3104, 1, 0,
                 pk(0, 32'h200C, 32'h210C, 1, 0, 1, 1));
    tbl[14] = mk(1, 32'h3008, 32'h3108, 1, 1, 32'h300C, 32'h310C, 1, 0,
                 pk(1, 32'h3000, 32'h3100, 1, 0, 1, 0));
    tbl[15] = mk(1, 32'h3010, 32'h3110, 1, 0, 0, 0, 0, 1,
                 pk(0, 32'h3000, 32'h3100, 1, 1, 0, 0));

    clear_in();
    rst = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("reset", pk(0, 32'h0, 32'h0, 0, 1, 0, 0));

    rst = 1'b1;
    sweep_check("sweep_por");

    for (int i = 0; i < 16; i++) begin
      upd_v0 = tbl[i].v0; upd_pc0 = tbl[i].pc0; upd_tgt0 = tbl[i].tgt0; upd_tkn0 = tbl[i].tkn0;
      upd_v1 = tbl[i].v1; upd_pc1 = tbl[i].pc1; upd_tgt1 = tbl[i].tgt1; upd_tkn1 = tbl[i].tkn1;
      flush_req = tbl[i].flush;
      step();
      chk($sformatf("vec%0d", i), tbl[i].exp);
    end
    clear_in();

    // Flush-started sweep, interrupted by reset after idx 499 has been written.
    for (int i = 0; i < 500; i++) begin
      step();
      chk("flush_sweep", pk(1, 32'(i * 4), RSTPC, 0, 1, 0, 0));
    end
    rst = 1'b0;
    #1;
    chk("mid_reset", pk(0, 32'h0, 32'h0, 0, 1, 0, 0));
    model_reset();
    step();
    chk("mid_reset_hold", pk(0, 32'h0, 32'h0, 0, 1, 0, 0));
    rst = 1'b1;
    sweep_check("sweep_restart");

    for (int n = 0; n < 5000; n++) begin
      upd_v0   = ($urandom_range(0, 9) < 6);
      upd_pc0  = 32'h4000 + 32'($urandom_range(0, 7) * 4);
      upd_tgt0 = $urandom;
      upd_tkn0 = 1'($urandom_range(0, 1));
      upd_v1   = ($urandom_range(0, 9) < 6);
      upd_pc1  = 32'h4000 + 32'($urandom_range(0, 7) * 4);
      upd_tgt1 = $urandom;
      upd_tkn1 = 1'($urandom_range(0, 1));
      flush_req = (n == 2500) || ($urandom_range(0, 2999) == 0);
      step();
      chk("random", {m_wr, m_adr, m_dat, m_val, m_busy, m_rdy0, m_rdy1});
    end
    clear_in();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
